// File: rtl/sc_input_conditioner.sv
// sc_input_conditioner: synchronises and debounces 10 slide switches and
// 4 active-low push buttons for the data memory's MMIO read port.
// Optional build macro KEY_EVENT_LATCH_EN turns `key` into sticky press
// events cleared by key_rd; without it `key` carries debounced levels.
module sc_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  sw_raw,
  input  logic [3:0]  key_n_raw,
  input  logic        key_rd,
  output logic [9:0]  sw,
  output logic [3:0]  key
);

  localparam int               NB      = 14;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [9:0]       sw_sync1_q, sw_sync1_d;
  logic [9:0]       sw_sync2_q, sw_sync2_d;
  logic [3:0]       key_n_sync1_q, key_n_sync1_d;
  logic [3:0]       key_n_sync2_q, key_n_sync2_d;
  logic [NB-1:0]    level;
  logic [NB-1:0]    stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [NB];
  logic [CNT_W-1:0] cnt_d [NB];

  // Synchroniser shift and per-bit debounce next-state
  always_comb begin
    sw_sync1_d    = sw_raw;
    sw_sync2_d    = sw_sync1_q;
    key_n_sync1_d = key_n_raw;
    key_n_sync2_d = key_n_sync1_q;
    // keys become active-high (pressed = 1) right after synchronisation
    level         = {~key_n_sync2_q, sw_sync2_q};
    stable_d      = stable_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = cnt_q[i];
      if (level[i] == stable_q[i]) begin
        cnt_d[i] = {CNT_W{1'b0}};
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = level[i];
        cnt_d[i]    = {CNT_W{1'b0}};
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Synchroniser, counter and stable-level registers
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_sync1_q    <= 10'h000;
      sw_sync2_q    <= 10'h000;
      key_n_sync1_q <= 4'hf;
      key_n_sync2_q <= 4'hf;
      stable_q      <= {NB{1'b0}};
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      sw_sync1_q    <= sw_sync1_d;
      sw_sync2_q    <= sw_sync2_d;
      key_n_sync1_q <= key_n_sync1_d;
      key_n_sync2_q <= key_n_sync2_d;
      stable_q      <= stable_d;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw = stable_q[9:0];

`ifdef KEY_EVENT_LATCH_EN
  logic [3:0] key_ev_q, key_ev_d;

  // Sticky press events: read clears, a simultaneous new press wins
  always_comb begin
    key_ev_d = (key_ev_q & ~{4{key_rd}}) | (stable_d[13:10] & ~stable_q[13:10]);
  end

  // Event register
  always_ff @(posedge clock) begin
    if (reset) begin
      key_ev_q <= 4'h0;
    end else begin
      key_ev_q <= key_ev_d;
    end
  end

  assign key = key_ev_q;
`else
  // level build has no read side effect, so the strobe is intentionally unused
  logic unused_key_rd;
  assign unused_key_rd = key_rd;
  assign key = stable_q[13:10];
`endif

endmodule

// File: tb/tb_sc_input_conditioner.sv
// Self-checking bench for sc_input_conditioner with DEBOUNCE_CYCLES=4.
// The reference model keeps a window of recent conditioned raw samples and
// flips a stable bit once the last D synchronised samples all disagree.
module tb_sc_input_conditioner;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] sw_raw = 10'h000;
  logic [3:0] key_n_raw = 4'hf;
  logic       key_rd = 1'b0;
  logic [9:0] sw;
  logic [3:0] key;

  int vectors = 0;
  int miscompares = 0;

  logic [13:0] hist[$];
  logic [13:0] m_stable = 14'h0000;
  logic [3:0]  m_ev = 4'h0;

  sc_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .sw_raw(sw_raw), .key_n_raw(key_n_raw),
    .key_rd(key_rd), .sw(sw), .key(key)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference behaviour for one clock edge given the inputs held before it.
  task automatic model_edge(input logic [9:0] s, input logic [3:0] kn,
                            input logic rd, input logic rst);
    logic [13:0] nxt;
    logic        all_diff;
    if (rst) begin
      hist.delete();
      for (int j = 0; j < D + 2; j++) hist.push_back(14'h0000);
      m_stable = 14'h0000;
      m_ev     = 4'h0;
    end else begin
      hist.push_back({~kn, s});
      while (hist.size() > D + 2) void'(hist.pop_front());
      // hist[0..D-1] are the sync2 values seen on the last D edges
      nxt = m_stable;
      for (int b = 0; b < 14; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++) if (hist[j][b] == m_stable[b]) all_diff = 1'b0;
        if (all_diff) nxt[b] = ~m_stable[b];
      end
      m_ev     = (rd ? 4'h0 : m_ev) | (nxt[13:10] & ~m_stable[13:10]);
      m_stable = nxt;
    end
  endtask

  function automatic logic [3:0] exp_key();
`ifdef KEY_EVENT_LATCH_EN
    return m_ev;
`else
    return m_stable[13:10];
`endif
  endfunction

  task automatic step(input logic [9:0] s, input logic [3:0] kn,
                      input logic rd, input logic rst);
    sw_raw = s; key_n_raw = kn; key_rd = rd; reset = rst;
    @(posedge clock);
    model_edge(s, kn, rd, rst);
    #1;
    check("sw", {6'h00, sw}, {6'h00, m_stable[9:0]});
    check("key", {12'h000, key}, {12'h000, exp_key()});
  endtask

  initial begin
    logic [9:0] rs;
    logic [3:0] rk;

    // reset then idle
    step(10'h000, 4'hf, 1'b0, 1'b1);
    step(10'h000, 4'hf, 1'b0, 1'b1);
    check("rst_sw", {6'h00, sw}, 16'h0000);
    check("rst_key", {12'h000, key}, 16'h0000);
    for (int i = 0; i < 6; i++) step(10'h000, 4'hf, 1'b0, 1'b0);

    // clean switch change
    for (int i = 1; i <= 8; i++) begin
      step(10'h2A5, 4'hf, 1'b0, 1'b0);
      if (i == 5) check("sw_edge5", {6'h00, sw}, 16'h0000);
      if (i == 6) check("sw_edge6", {6'h00, sw}, 16'h02A5);
    end
    for (int i = 0; i < 8; i++) step(10'h000, 4'hf, 1'b0, 1'b0);

    // bounce: 3-cycle pulses never pass, final hold passes at edge 6
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 3; i++) begin
        step((p % 2 == 0) ? 10'h001 : 10'h000, 4'hf, 1'b0, 1'b0);
        check("bounce_low", {15'h0000, sw[0]}, 16'h0000);
      end
    for (int i = 1; i <= 8; i++) begin
      step(10'h001, 4'hf, 1'b0, 1'b0);
      if (i == 5) check("bounce_e5", {15'h0000, sw[0]}, 16'h0000);
      if (i == 6) check("bounce_e6", {15'h0000, sw[0]}, 16'h0001);
    end
    for (int i = 0; i < 8; i++) step(10'h000, 4'hf, 1'b0, 1'b0);

    // key2 press for 20 cycles, then release
    for (int i = 1; i <= 20; i++) begin
      step(10'h000, 4'hb, 1'b0, 1'b0);
      if (i == 5) check("key2_e5", {12'h000, key}, 16'h0000);
      if (i == 6) check("key2_e6", {12'h000, key}, 16'h0004);
    end
    for (int i = 0; i < 8; i++) step(10'h000, 4'hf, 1'b0, 1'b0);
    step(10'h000, 4'hf, 1'b1, 1'b0);
    check("key2_after_rd", {12'h000, key}, 16'h0000);

    // key0 press/release, then read-to-clear
    for (int i = 0; i < 8; i++) step(10'h000, 4'he, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(10'h000, 4'hf, 1'b0, 1'b0);
`ifdef KEY_EVENT_LATCH_EN
    check("key0_sticky", {12'h000, key}, 16'h0001);
`else
    check("key0_released", {12'h000, key}, 16'h0000);
`endif
    step(10'h000, 4'hf, 1'b1, 1'b0);
    check("key0_clear", {12'h000, key}, 16'h0000);
    step(10'h000, 4'hf, 1'b1, 1'b0);
    check("key0_second_rd", {12'h000, key}, 16'h0000);

    // key1 becomes stable on edge 6 with key_rd high in that cycle
    for (int i = 1; i <= 6; i++) step(10'h000, 4'hd, (i == 6), 1'b0);
    check("key1_set_wins", {12'h000, key}, 16'h0002);
    for (int i = 0; i < 8; i++) step(10'h000, 4'hf, 1'b0, 1'b0);
    step(10'h000, 4'hf, 1'b1, 1'b0);

    // reset mid-count discards progress; count restarts afterwards
    for (int i = 1; i <= 3; i++) step(10'h000, 4'hd, 1'b0, 1'b0);
    step(10'h000, 4'hd, 1'b0, 1'b1);
    check("mid_rst_key", {12'h000, key}, 16'h0000);
    for (int i = 1; i <= 6; i++) begin
      step(10'h000, 4'hd, 1'b0, 1'b0);
      if (i == 5) check("restart_e5", {12'h000, key}, 16'h0000);
      if (i == 6) check("restart_e6", {12'h000, key}, 16'h0002);
    end

    // randomized traffic with sparse toggles so some changes survive
    rs = 10'h000;
    rk = 4'hf;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 10; b++) if ($urandom_range(7) == 0) rs[b] = ~rs[b];
      for (int b = 0; b < 4; b++)  if ($urandom_range(7) == 0) rk[b] = ~rk[b];
      step(rs, rk, ($urandom_range(5) == 0), ($urandom_range(499) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
